// File: rtl/uart_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arb_pkg
//   Shared types and constants for the UART transmit arbiter.
//   - arb_state_t : arbiter FSM states
//   - TAG_BASE    : upper nibble of the per-stream tag byte
//   - bytes_ceil  : number of whole bytes needed to hold w bits
// ----------------------------------------------------------------------------
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   localparam logic [7:0] TAG_BASE = 8'hA0;

   function automatic int bytes_ceil(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
//   Combinational round-robin picker. Returns the first asserted request at
//   or after the priority pointer, wrapping at NUM_REQ.
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   ID_W     highest-priority index (0..NUM_REQ-1)
//   grant  out  ID_W     selected index (0 when any=0)
//   any    out  1        at least one request asserted
// ----------------------------------------------------------------------------
module uart_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    grant,
   output logic               any
);

   always_comb begin
      int idx;
      grant = '0;
      any   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Explicit wrap so non-power-of-two NUM_REQ works too.
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && req[idx]) begin
            any   = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one multi-byte UART sender among NUM_REQ requesters with a
//   round-robin grant. The granted word is zero-padded to whole bytes and
//   prefixed (in the MSB byte, sent last) with tag 8'hA0 | id.
//
// Optional feature macro: UART_TX_ARB_WDOG_EN
//   When defined, a watchdog aborts a frame whose sender does not return to
//   idle within WDOG_CYCLES cycles of the grant (wdog_err pulses, busy drops,
//   pointer kept). When undefined, wdog_err is constant 0.
//
// Ports
//   sys_clk    in   1                   clock
//   sys_rst    in   1                   synchronous active-high reset
//   arb_en     in   1                   0 = no new grants
//   req_valid  in   NUM_REQ             level requests
//   req_data   in   NUM_REQ*SEND_WIDTH  word i at [i*SEND_WIDTH +: SEND_WIDTH]
//   req_ack    out  NUM_REQ             one-cycle capture pulse
//   tx_en      out  1                   one-cycle launch pulse
//   tx_data    out  TX_WIDTH            {tag, zero pad, payload}
//   tx_done    in   1                   sender idle level
//   busy       out  1                   grant until sender idle again
//   cur_id     out  ID_W                id of last grant
//   wdog_err   out  1                   watchdog abort pulse
// ----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int SEND_WIDTH  = 19,
   parameter  int WDOG_CYCLES = 2**24,
   localparam int PAD_W       = bytes_ceil(SEND_WIDTH) * 8,
   localparam int TX_WIDTH    = PAD_W + 8,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*SEND_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic                          tx_en,
   output logic [TX_WIDTH-1:0]           tx_data,
   input  logic                          tx_done,
   output logic                          busy,
   output logic [ID_W-1:0]               cur_id,
   output logic                          wdog_err
);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..16");
   end
   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("uart_tx_arbiter: WDOG_CYCLES must be >= 1");
   end

   arb_state_t          state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic [SEND_WIDTH-1:0] sel_word;
   logic [ID_W-1:0]     next_ptr;
   logic                wdog_hit;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (pick_idx),
      .any   (pick_any)
   );

   // Payload mux for the candidate winner; only sampled on the grant edge.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == ID_W'(i)) sel_word = req_data[i*SEND_WIDTH +: SEND_WIDTH];
      end
   end

   assign next_ptr = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef UART_TX_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt;

   // Fires on the WDOG_CYCLES-th edge after the grant edge.
   assign wdog_hit = (state != IDLE) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wdog_cnt <= '0;
      end else if (state == IDLE) begin
         wdog_cnt <= '0;
      end else begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         req_ack  <= '0;
         tx_en    <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
         cur_id   <= '0;
         wdog_err <= 1'b0;
      end else begin
         req_ack  <= '0;
         tx_en    <= 1'b0;
         wdog_err <= 1'b0;
         case (state)
            IDLE: begin
               // tx_done gating also protects against a frame still running
               // in the sender after a reset or watchdog abort.
               if (arb_en && tx_done && pick_any) begin
                  req_ack  <= NUM_REQ'(1) << pick_idx;
                  tx_en    <= 1'b1;
                  tx_data  <= {TAG_BASE | 8'(pick_idx), PAD_W'(sel_word)};
                  cur_id   <= pick_idx;
                  busy     <= 1'b1;
                  rr_ptr   <= next_ptr;
                  state    <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (wdog_hit) begin
                  wdog_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (!tx_done) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (wdog_hit) begin
                  wdog_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (tx_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam logic [18:0] W0 = 19'h5_A5A5;
   localparam logic [18:0] W1 = 19'h1_2345;
   localparam logic [18:0] W2 = 19'h7_FFFF;
   localparam logic [18:0] W3 = 19'h0_0001;
   localparam logic [31:0] D0 = 32'hA005A5A5;
   localparam logic [31:0] D1 = 32'hA1012345;
   localparam logic [31:0] D2 = 32'hA207FFFF;
   localparam logic [31:0] D3 = 32'hA3000001;
   localparam int NV = 25;

   logic        clk;
   logic        rst;
   logic        arb_en;
   logic [3:0]  req_valid;
   logic [75:0] req_data;
   logic [3:0]  req_ack;
   logic        tx_en;
   logic [31:0] tx_data;
   logic        tx_done;
   logic        busy;
   logic [1:0]  cur_id;
   logic        wdog_err;

   logic        use_model;
   logic        drv_done;
   logic        mdl_done;
   int          mcnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  rv;
      logic        done;
      logic        ten;
      logic [3:0]  ack;
      logic        bsy;
      logic [1:0]  id;
      logic [31:0] data;
   } vec_t;

   vec_t vecs [NV];

   uart_tx_arbiter #(
      .NUM_REQ     (4),
      .SEND_WIDTH  (19),
      .WDOG_CYCLES (16)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .arb_en    (arb_en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ack   (req_ack),
      .tx_en     (tx_en),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .busy      (busy),
      .cur_id    (cur_id),
      .wdog_err  (wdog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sender model: drops idle the cycle after launch, idle again 10 cycles later.
   assign tx_done = use_model ? mdl_done : drv_done;

   always @(posedge clk) begin
      if (!use_model) begin
         mdl_done <= 1'b1;
         mcnt     <= 0;
      end else if (tx_en) begin
         mdl_done <= 1'b0;
         mcnt     <= 10;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) mdl_done <= 1'b1;
      end
   end

   function automatic vec_t mk(input logic r, input logic e, input logic [3:0] v,
                               input logic d, input logic t, input logic [3:0] a,
                               input logic b, input logic [1:0] i, input logic [31:0] x);
      vec_t s;
      s.rst = r; s.en = e; s.rv = v; s.done = d;
      s.ten = t; s.ack = a; s.bsy = b; s.id = i; s.data = x;
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int found;
      int seen;
      logic [1:0] exp_ids [5];

      use_model = 1'b0;
      drv_done  = 1'b1;
      rst       = 1'b1;
      arb_en    = 1'b0;
      req_valid = 4'b0000;
      req_data  = {W3, W2, W1, W0};

      vecs[0]  = mk(1, 0, 4'b0000, 1,  0, 4'b0000, 0, 0, 32'h0);
      vecs[1]  = mk(0, 1, 4'b0001, 1,  1, 4'b0001, 1, 0, D0);
      vecs[2]  = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 1, 0, D0);
      vecs[3]  = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 0, D0);
      vecs[4]  = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 0, D0);
      vecs[5]  = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 0, 0, D0);
      vecs[6]  = mk(0, 1, 4'b0010, 1,  1, 4'b0010, 1, 1, D1);
      vecs[7]  = mk(0, 1, 4'b0011, 0,  0, 4'b0000, 1, 1, D1);
      vecs[8]  = mk(0, 1, 4'b0011, 1,  0, 4'b0000, 0, 1, D1);
      vecs[9]  = mk(0, 1, 4'b0011, 1,  1, 4'b0001, 1, 0, D0);
      vecs[10] = mk(0, 1, 4'b0010, 0,  0, 4'b0000, 1, 0, D0);
      vecs[11] = mk(0, 1, 4'b0010, 1,  0, 4'b0000, 0, 0, D0);
      vecs[12] = mk(0, 1, 4'b0010, 1,  1, 4'b0010, 1, 1, D1);
      vecs[13] = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 1, D1);
      vecs[14] = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 0, 1, D1);
      vecs[15] = mk(0, 1, 4'b1111, 1,  1, 4'b0100, 1, 2, D2);
      vecs[16] = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 2, D2);
      vecs[17] = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 0, 2, D2);
      vecs[18] = mk(0, 1, 4'b0100, 1,  1, 4'b0100, 1, 2, D2);
      vecs[19] = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 2, D2);
      vecs[20] = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 0, 2, D2);
      vecs[21] = mk(0, 1, 4'b1000, 0,  0, 4'b0000, 0, 2, D2);
      vecs[22] = mk(0, 1, 4'b1000, 1,  1, 4'b1000, 1, 3, D3);
      vecs[23] = mk(0, 1, 4'b0000, 0,  0, 4'b0000, 1, 3, D3);
      vecs[24] = mk(0, 1, 4'b0000, 1,  0, 4'b0000, 0, 3, D3);

      // Table: single grant, pointer wrap, lone requester, tx_done gating.
      for (int v = 0; v < NV; v++) begin
         rst       = vecs[v].rst;
         arb_en    = vecs[v].en;
         req_valid = vecs[v].rv;
         drv_done  = vecs[v].done;
         tick();
         chk($sformatf("v%0d tx_en", v),    64'(tx_en),    64'(vecs[v].ten));
         chk($sformatf("v%0d req_ack", v),  64'(req_ack),  64'(vecs[v].ack));
         chk($sformatf("v%0d busy", v),     64'(busy),     64'(vecs[v].bsy));
         chk($sformatf("v%0d cur_id", v),   64'(cur_id),   64'(vecs[v].id));
         chk($sformatf("v%0d tx_data", v),  64'(tx_data),  64'(vecs[v].data));
         chk($sformatf("v%0d wdog_err", v), 64'(wdog_err), 64'(0));
      end

      // All four requesting with the sender model: strict rotation 0,1,2,3,0.
      rst = 1'b1; req_valid = 4'b0000; drv_done = 1'b1;
      tick();
      rst = 1'b0; use_model = 1'b1; arb_en = 1'b1; req_valid = 4'b1111;
      exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2;
      exp_ids[3] = 2'd3; exp_ids[4] = 2'd0;
      for (int g = 0; g < 5; g++) begin
         found = 0;
         for (int c = 0; c < 50 && found == 0; c++) begin
            tick();
            if (tx_en) found = 1;
         end
         chk($sformatf("rr%0d grant seen", g), 64'(found), 64'(1));
         if (found == 1) begin
            chk($sformatf("rr%0d cur_id", g), 64'(cur_id), 64'(exp_ids[g]));
            chk($sformatf("rr%0d tag", g), 64'(tx_data[31:24]), 64'(8'hA0 | 8'(exp_ids[g])));
            chk($sformatf("rr%0d req_ack", g), 64'(req_ack), 64'(4'b0001 << exp_ids[g]));
         end
      end
      req_valid = 4'b0000;
      found = 0;
      for (int c = 0; c < 50 && found == 0; c++) begin
         tick();
         if (!busy) found = 1;
      end
      chk("rr final idle", 64'(found), 64'(1));
      use_model = 1'b0; drv_done = 1'b1;

      // Reset in WAIT_DONE while the sender is still busy.
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 4'b0001; drv_done = 1'b1;
      tick();
      chk("rst4 grant", 64'(tx_en), 64'(1));
      req_valid = 4'b0000; drv_done = 1'b0;
      tick(); tick();
      chk("rst4 busy before reset", 64'(busy), 64'(1));
      rst = 1'b1; req_valid = 4'b0001;
      tick();
      rst = 1'b0;
      chk("rst4 outputs zero",
          64'({req_ack, tx_en, tx_data, busy, cur_id, wdog_err}), 64'(0));
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (tx_en || req_ack != 4'b0000) seen = 1;
      end
      chk("rst4 no launch while sender busy", 64'(seen), 64'(0));
      drv_done = 1'b1;
      tick();
      chk("rst4 launch after idle", 64'(tx_en), 64'(1));
      chk("rst4 ack after idle", 64'(req_ack), 64'(4'b0001));
      req_valid = 4'b0000; drv_done = 1'b0; tick();
      drv_done = 1'b1; tick();
      chk("rst4 frame end", 64'(busy), 64'(0));

      // arb_en low: requests (including one that is withdrawn) are ignored.
      arb_en = 1'b0; req_valid = 4'b0101;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (c == 25) req_valid = 4'b0100;
         tick();
         if (tx_en || req_ack != 4'b0000 || busy) seen = 1;
      end
      chk("en5 no grant while disabled", 64'(seen), 64'(0));
      arb_en = 1'b1;
      tick();
      chk("en5 tx_en", 64'(tx_en), 64'(1));
      chk("en5 req_ack", 64'(req_ack), 64'(4'b0100));
      chk("en5 cur_id", 64'(cur_id), 64'(2));
      chk("en5 tx_data", 64'(tx_data), 64'(D2));
      req_valid = 4'b0000;
      arb_en = 1'b0; drv_done = 1'b0; tick();
      chk("en5 frame continues", 64'(busy), 64'(1));
      drv_done = 1'b1; tick();
      chk("en5 frame end", 64'(busy), 64'(0));
      arb_en = 1'b1;

`ifdef UART_TX_ARB_WDOG_EN
      // Watchdog: sender never returns idle.
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 4'b0001; drv_done = 1'b1;
      tick();
      chk("wd6 grant", 64'(tx_en), 64'(1));
      req_valid = 4'b0000; drv_done = 1'b0;
      k = 0;
      for (int c = 1; c <= 40 && k == 0; c++) begin
         tick();
         if (wdog_err) k = c;
      end
      chk("wd6 pulse delay", 64'(k), 64'(16));
      chk("wd6 busy cleared", 64'(busy), 64'(0));
      req_valid = 4'b0001;
      tick();
      chk("wd6 pulse width", 64'(wdog_err), 64'(0));
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (tx_en) seen = 1;
      end
      chk("wd6 no grant while sender busy", 64'(seen), 64'(0));
      drv_done = 1'b1;
      tick();
      chk("wd6 grant after idle", 64'(tx_en), 64'(1));
      chk("wd6 pointer kept", 64'(cur_id), 64'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
